operand_fetch_sequencer: RTL

Upstream controller for the register bank (8 × 16-bit registers, 8-bit high/low byte access, shared bidirectional `data` bus). It accepts one register-operation request at a time and reads two source registers over the bank bus. It presents both operands to the execution stage, then optionally writes the returned result back into a destination register. It is the only master of the bank's control pins and `data` bus.

---
 rtl/operand_fetch_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_sequencer.sv
// Register-bank master: reads two operands, hands them to execute, optionally writes the result back.
// Build option OPERAND_REUSE_EN: identical source operands are read once (2-cycle operand latency).
module operand_fetch_sequencer #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_src_a,
    input  logic [SEL_W-1:0]  req_src_b,
    input  logic [SEL_W-1:0]  req_dst,
    input  logic              req_hl_a,
    input  logic              req_hl_b,
    input  logic              req_hl_dst,
    input  logic              req_size,
    input  logic              req_wb,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              err,
    output logic [SEL_W-1:0]  select_reg,
    output logic              size,
    output logic              select_high_low,
    output logic              select_data_h_reg,
    output logic              read_write,
    inout  wire  [DATA_W-1:0] data
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, OP_OUT, WAIT_RES, WR} state_t;

    state_t             state;
    logic [SEL_W-1:0]   l_src_b;
    logic [SEL_W-1:0]   l_dst;
    logic               l_hl_b;
    logic               l_hl_dst;
    logic               l_size;
    logic               l_wb;
    logic [DATA_W-1:0]  wr_dat;
    logic [DATA_W-1:0]  rd_val;
    logic               illegal;
`ifdef OPERAND_REUSE_EN
    logic               l_reuse;
`endif

    // In 8-bit mode only registers 0..3 are addressable.
    always_comb begin
        illegal = 1'b0;
        if (!req_size) begin
            illegal = (req_src_a > SEL_W'(3)) || (req_src_b > SEL_W'(3)) ||
                      (req_wb && (req_dst > SEL_W'(3)));
        end
        rd_val = l_size ? data : {{(DATA_W-8){1'b0}}, data[7:0]};
    end

    assign select_data_h_reg = select_high_low;
    assign data = read_write ? wr_dat : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            op_valid        <= 1'b0;
            res_ready       <= 1'b0;
            err             <= 1'b0;
            read_write      <= 1'b0;
            select_reg      <= '0;
            size            <= 1'b1;
            select_high_low <= 1'b0;
            op_a            <= '0;
            op_b            <= '0;
            wr_dat          <= '0;
            l_src_b         <= '0;
            l_dst           <= '0;
            l_hl_b          <= 1'b0;
            l_hl_dst        <= 1'b0;
            l_size          <= 1'b1;
            l_wb            <= 1'b0;
`ifdef OPERAND_REUSE_EN
            l_reuse         <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            l_src_b         <= req_src_b;
                            l_dst           <= req_dst;
                            l_hl_b          <= req_hl_b;
                            l_hl_dst        <= req_hl_dst;
                            l_size          <= req_size;
                            l_wb            <= req_wb;
`ifdef OPERAND_REUSE_EN
                            l_reuse         <= (req_src_a == req_src_b) && (req_hl_a == req_hl_b);
`endif
                            req_ready       <= 1'b0;
                            select_reg      <= req_src_a;
                            size            <= req_size;
                            select_high_low <= req_size ? 1'b0 : req_hl_a;
                            state           <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    op_a <= rd_val;
`ifdef OPERAND_REUSE_EN
                    if (l_reuse) begin
                        op_b            <= rd_val;
                        op_valid        <= 1'b1;
                        select_reg      <= '0;
                        size            <= 1'b1;
                        select_high_low <= 1'b0;
                        state           <= OP_OUT;
                    end else begin
                        select_reg      <= l_src_b;
                        select_high_low <= l_size ? 1'b0 : l_hl_b;
                        state           <= RD_B;
                    end
`else
                    select_reg      <= l_src_b;
                    select_high_low <= l_size ? 1'b0 : l_hl_b;
                    state           <= RD_B;
`endif
                end
                RD_B: begin
                    op_b            <= rd_val;
                    op_valid        <= 1'b1;
                    select_reg      <= '0;
                    size            <= 1'b1;
                    select_high_low <= 1'b0;
                    state           <= OP_OUT;
                end
                OP_OUT: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        if (l_wb) begin
                            res_ready <= 1'b1;
                            state     <= WAIT_RES;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        res_ready       <= 1'b0;
                        wr_dat          <= l_size ? res_data : {{(DATA_W-8){1'b0}}, res_data[7:0]};
                        select_reg      <= l_dst;
                        size            <= l_size;
                        select_high_low <= l_size ? 1'b0 : l_hl_dst;
                        read_write      <= 1'b1;
                        state           <= WR;
                    end
                end
                WR: begin
                    // Bank captures the write on the edge that leaves this state.
                    read_write      <= 1'b0;
                    select_reg      <= '0;
                    size            <= 1'b1;
                    select_high_low <= 1'b0;
                    req_ready       <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
